// File: rtl/st4_pkg.sv
// Shared types and constants for the stage-4 memory block.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: word width, exception cause encodings, FSM state type, and
// the fault-priority helper used by st4_mem.
package st4_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_OVF   = 2'b01,
    CAUSE_ALIGN = 2'b10,
    CAUSE_RANGE = 2'b11
  } cause_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  // Overflow outranks address faults; misalignment outranks range.
  function automatic cause_e fault_cause(input logic ovf,
                                         input logic misalign,
                                         input logic range_err);
    if (ovf)            return CAUSE_OVF;
    else if (misalign)  return CAUSE_ALIGN;
    else if (range_err) return CAUSE_RANGE;
    else                return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/st4_dmem.sv
// Single-port synchronous data RAM, one 16-bit word per entry.
// Latency: write lands at the enabled edge; read data is registered, valid after the edge.
// Backpressure: none; one access per cycle when en is high.
//
// Ports:
//   clk            rising-edge clock
//   en             access enable (read when we=0, write when we=1)
//   we             write enable
//   addr  [AW-1:0] word index
//   wdata [15:0]   write data
//   rdata [15:0]   registered read data; holds when not reading
// Contents are intentionally not reset.
module st4_dmem
  import st4_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  word_t                    wdata,
  output word_t                    rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/st4_mem.sv
// Pipeline stage 4: word load/store, precise exception capture, MEM/WB register.
// Latency: one cycle from EX/MEM inputs to MEM/WB outputs (load data included).
// Backpressure: none; one instruction per cycle, faults halt until excClear.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   valid_in, pc_in               EX/MEM slot valid and its PC
//   memRead, memWrite             load / store (mutually exclusive)
//   regWrite, r15Write, wbReg_in  write-back controls and destination
//   aluOut1, aluOut2, storeData   ALU results (aluOut1 = byte address) and store value
//   ALU_exception                 overflow from stage 3
//   excClear                      leave HALT
//   wbValid, wbRegWrite, wbR15Write, wbReg, wbData, wbData2   MEM/WB bundle
//   excpt, excCause, epc          one-cycle exception pulse, cause, faulting PC
//   flush                         combinational squash of stages 1-3
// Build option: define ST4_MEM_ALIGN_CHECK_EN to enable misaligned and
// out-of-range address faults; otherwise the address LSB is ignored and
// upper address bits wrap modulo DEPTH.
module st4_mem
  import st4_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] pc_in,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        regWrite,
  input  logic        r15Write,
  input  logic [3:0]  wbReg_in,
  input  logic [15:0] aluOut1,
  input  logic [15:0] aluOut2,
  input  logic [15:0] storeData,
  input  logic        ALU_exception,
  input  logic        excClear,
  output logic        wbValid,
  output logic        wbRegWrite,
  output logic        wbR15Write,
  output logic [3:0]  wbReg,
  output logic [15:0] wbData,
  output logic [15:0] wbData2,
  output logic        excpt,
  output logic [1:0]  excCause,
  output logic [15:0] epc,
  output logic        flush
);

  localparam int AW = $clog2(DEPTH);

  state_e        state;
  logic [AW-1:0] word_idx;
  logic          mem_op;
  logic          misalign;
  logic          out_of_range;
  cause_e        cur_cause;
  logic          fault;
  logic          accept;
  word_t         ram_rdata;
  word_t         alu_q;
  logic          ld_q;

  // Byte address to word index; without the address checks the LSB is
  // simply dropped and anything above the RAM wraps.
  assign word_idx = aluOut1[AW:1];
  assign mem_op   = memRead | memWrite;

`ifdef ST4_MEM_ALIGN_CHECK_EN
  assign misalign     = mem_op & aluOut1[0];
  assign out_of_range = mem_op & ((aluOut1 >> (AW + 1)) != '0);
`else
  assign misalign     = 1'b0;
  assign out_of_range = 1'b0;
`endif

  // Bubbles never fault, so the cause is masked by valid_in.
  assign cur_cause = valid_in ? fault_cause(ALU_exception, misalign, out_of_range)
                              : CAUSE_NONE;
  assign fault     = (state == RUN) && (cur_cause != CAUSE_NONE);
  assign accept    = (state == RUN) && valid_in && !fault;
  assign flush     = fault || (state == HALT);

  // RAM is only touched by accepted memory ops, so a suppressed store never
  // writes and the read register holds while nothing is loading.
  st4_dmem #(
    .DEPTH (DEPTH)
  ) u_dmem (
    .clk   (clk),
    .en    (accept & mem_op),
    .we    (memWrite),
    .addr  (word_idx),
    .wdata (storeData),
    .rdata (ram_rdata)
  );

  // The RAM read register already is the pipeline register for load data,
  // so the MEM/WB data field selects between it and the registered ALU result.
  assign wbData = ld_q ? ram_rdata : alu_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wbValid    <= 1'b0;
      wbRegWrite <= 1'b0;
      wbR15Write <= 1'b0;
      wbReg      <= '0;
      alu_q      <= '0;
      ld_q       <= 1'b0;
      wbData2    <= '0;
      excpt      <= 1'b0;
      excCause   <= CAUSE_NONE;
      epc        <= '0;
    end else begin
      // Pulses and write-back controls default low; data fields hold.
      excpt      <= 1'b0;
      wbValid    <= 1'b0;
      wbRegWrite <= 1'b0;
      wbR15Write <= 1'b0;
      case (state)
        RUN: begin
          if (fault) begin
            excpt    <= 1'b1;
            excCause <= cur_cause;
            epc      <= pc_in;
            state    <= HALT;
          end else if (accept) begin
            wbValid    <= 1'b1;
            wbRegWrite <= regWrite;
            wbR15Write <= r15Write;
            wbReg      <= wbReg_in;
            alu_q      <= aluOut1;
            ld_q       <= memRead;
            wbData2    <= aluOut2;
          end
        end
        HALT: begin
          // The instruction presented alongside excClear is dropped.
          if (excClear) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_st4_mem.sv
// Directed self-checking bench for st4_mem (DEPTH=256).
// Latency: n/a. Backpressure: n/a.
// Address-check expectations follow ST4_MEM_ALIGN_CHECK_EN as seen by this compile.
module tb_st4_mem;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [15:0] pc_in;
  logic        memRead;
  logic        memWrite;
  logic        regWrite;
  logic        r15Write;
  logic [3:0]  wbReg_in;
  logic [15:0] aluOut1;
  logic [15:0] aluOut2;
  logic [15:0] storeData;
  logic        ALU_exception;
  logic        excClear;
  logic        wbValid;
  logic        wbRegWrite;
  logic        wbR15Write;
  logic [3:0]  wbReg;
  logic [15:0] wbData;
  logic [15:0] wbData2;
  logic        excpt;
  logic [1:0]  excCause;
  logic [15:0] epc;
  logic        flush;

  int checks   = 0;
  int failures = 0;

  st4_mem #(.DEPTH(256)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .pc_in         (pc_in),
    .memRead       (memRead),
    .memWrite      (memWrite),
    .regWrite      (regWrite),
    .r15Write      (r15Write),
    .wbReg_in      (wbReg_in),
    .aluOut1       (aluOut1),
    .aluOut2       (aluOut2),
    .storeData     (storeData),
    .ALU_exception (ALU_exception),
    .excClear      (excClear),
    .wbValid       (wbValid),
    .wbRegWrite    (wbRegWrite),
    .wbR15Write    (wbR15Write),
    .wbReg         (wbReg),
    .wbData        (wbData),
    .wbData2       (wbData2),
    .excpt         (excpt),
    .excCause      (excCause),
    .epc           (epc),
    .flush         (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies one EX/MEM slot at the falling edge.
  task automatic drive(input logic v, input logic [15:0] pc, input logic rd, input logic wr,
                       input logic rw, input logic r15, input logic [3:0] rg,
                       input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] sd,
                       input logic ovf, input logic clr);
    @(negedge clk);
    valid_in = v; pc_in = pc; memRead = rd; memWrite = wr; regWrite = rw;
    r15Write = r15; wbReg_in = rg; aluOut1 = a1; aluOut2 = a2; storeData = sd;
    ALU_exception = ovf; excClear = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_in = 0; pc_in = 0; memRead = 0; memWrite = 0; regWrite = 0; r15Write = 0;
    wbReg_in = 0; aluOut1 = 0; aluOut2 = 0; storeData = 0; ALU_exception = 0; excClear = 0;
    tick(); tick();
    checks++; if ({wbValid, wbRegWrite, wbR15Write, excpt, flush} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {wbValid, wbRegWrite, wbR15Write, excpt, flush});
    end
    checks++; if ({wbReg, excCause} !== 6'h0) begin
      failures++; $display("FAIL reset_reg_cause got=%h exp=0", {wbReg, excCause});
    end
    checks++; if ({wbData, wbData2, epc} !== 48'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {wbData, wbData2, epc});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    drive(1, 16'h0010, 0, 1, 0, 0, 4'd0, 16'h0010, 16'h0, 16'h1234, 0, 0);
    #1;
    checks++; if (flush !== 1'b0) begin
      failures++; $display("FAIL store_flush got=%b exp=0", flush);
    end
    tick();
    checks++; if (wbValid !== 1'b1) begin
      failures++; $display("FAIL store_wbvalid got=%b exp=1", wbValid);
    end
    drive(1, 16'h0012, 1, 0, 1, 0, 4'd5, 16'h0010, 16'h0, 16'h0, 0, 0);
    tick();
    checks++; if (wbValid !== 1'b1 || wbRegWrite !== 1'b1) begin
      failures++; $display("FAIL load_ctrl got=%b%b exp=11", wbValid, wbRegWrite);
    end
    checks++; if (wbData !== 16'h1234) begin
      failures++; $display("FAIL load_data got=%h exp=1234", wbData);
    end
    checks++; if (wbReg !== 4'd5) begin
      failures++; $display("FAIL load_reg got=%0d exp=5", wbReg);
    end
  endtask

  task automatic test_passthru();
    drive(1, 16'h0014, 0, 0, 1, 1, 4'd3, 16'h0064, 16'h0000, 16'h0, 0, 0);
    tick();
    checks++; if (wbData !== 16'h0064 || wbData2 !== 16'h0000) begin
      failures++; $display("FAIL pass_data got=%h/%h exp=0064/0000", wbData, wbData2);
    end
    checks++; if (wbR15Write !== 1'b1 || wbReg !== 4'd3 || wbValid !== 1'b1) begin
      failures++; $display("FAIL pass_ctrl got=%b/%0d/%b exp=1/3/1", wbR15Write, wbReg, wbValid);
    end
    drive(1, 16'h0016, 0, 0, 0, 0, 4'hF, 16'hFFFF, 16'hABCD, 16'h0, 0, 0);
    tick();
    checks++; if (wbData !== 16'hFFFF || wbData2 !== 16'hABCD) begin
      failures++; $display("FAIL pass2_data got=%h/%h exp=ffff/abcd", wbData, wbData2);
    end
    checks++; if (wbR15Write !== 1'b0 || wbRegWrite !== 1'b0 || wbReg !== 4'hF) begin
      failures++; $display("FAIL pass2_ctrl got=%b/%b/%h exp=0/0/f", wbR15Write, wbRegWrite, wbReg);
    end
  endtask

  task automatic test_bubble();
    // A bubble carrying an overflow flag and a store must do nothing.
    drive(0, 16'h0018, 0, 1, 0, 0, 4'd0, 16'h0010, 16'h0, 16'hBAD0, 1, 0);
    #1;
    checks++; if (flush !== 1'b0) begin
      failures++; $display("FAIL bubble_flush got=%b exp=0", flush);
    end
    tick();
    checks++; if (wbValid !== 1'b0 || excpt !== 1'b0) begin
      failures++; $display("FAIL bubble_out got=%b%b exp=00", wbValid, excpt);
    end
  endtask

  task automatic test_overflow();
    drive(1, 16'h0040, 0, 1, 0, 0, 4'd0, 16'h0010, 16'h0, 16'hDEAD, 1, 0);
    #1;
    checks++; if (flush !== 1'b1) begin
      failures++; $display("FAIL ovf_flush got=%b exp=1", flush);
    end
    tick();
    checks++; if (excpt !== 1'b1 || excCause !== 2'b01 || epc !== 16'h0040 || wbValid !== 1'b0) begin
      failures++; $display("FAIL ovf_capture got=%b/%b/%h/%b exp=1/01/0040/0", excpt, excCause, epc, wbValid);
    end
    drive(1, 16'h0044, 0, 1, 0, 0, 4'd0, 16'h0010, 16'h0, 16'hBEEF, 0, 0);
    #1;
    checks++; if (flush !== 1'b1) begin
      failures++; $display("FAIL halt_flush got=%b exp=1", flush);
    end
    tick();
    checks++; if (excpt !== 1'b0 || excCause !== 2'b01 || epc !== 16'h0040 || wbValid !== 1'b0) begin
      failures++; $display("FAIL halt_hold got=%b/%b/%h/%b exp=0/01/0040/0", excpt, excCause, epc, wbValid);
    end
    // Store presented with excClear is dropped.
    drive(1, 16'h0046, 0, 1, 0, 0, 4'd0, 16'h0010, 16'h0, 16'h5555, 0, 1);
    tick();
    checks++; if (wbValid !== 1'b0) begin
      failures++; $display("FAIL clear_drop got=%b exp=0", wbValid);
    end
    drive(1, 16'h0048, 1, 0, 1, 0, 4'd7, 16'h0010, 16'h0, 16'h0, 0, 0);
    #1;
    checks++; if (flush !== 1'b0) begin
      failures++; $display("FAIL resume_flush got=%b exp=0", flush);
    end
    tick();
    checks++; if (wbValid !== 1'b1 || wbData !== 16'h1234) begin
      failures++; $display("FAIL mem_unchanged got=%b/%h exp=1/1234", wbValid, wbData);
    end
  endtask

  task automatic test_misaligned();
    drive(1, 16'h0050, 1, 0, 1, 0, 4'd2, 16'h0011, 16'h0, 16'h0, 0, 0);
`ifdef ST4_MEM_ALIGN_CHECK_EN
    #1;
    checks++; if (flush !== 1'b1) begin
      failures++; $display("FAIL align_flush got=%b exp=1", flush);
    end
    tick();
    checks++; if (excpt !== 1'b1 || excCause !== 2'b10 || epc !== 16'h0050 || wbValid !== 1'b0) begin
      failures++; $display("FAIL align_capture got=%b/%b/%h/%b exp=1/10/0050/0", excpt, excCause, epc, wbValid);
    end
    drive(0, 16'h0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 1);
    tick();
`else
    #1;
    checks++; if (flush !== 1'b0) begin
      failures++; $display("FAIL align_flush got=%b exp=0", flush);
    end
    tick();
    checks++; if (wbValid !== 1'b1 || wbData !== 16'h1234) begin
      failures++; $display("FAIL align_ignored got=%b/%h exp=1/1234", wbValid, wbData);
    end
`endif
  endtask

  task automatic test_range();
    drive(1, 16'h005E, 0, 1, 0, 0, 4'd0, 16'h0000, 16'h0, 16'h0A0A, 0, 0);
    tick();
    drive(1, 16'h0060, 0, 1, 0, 0, 4'd0, 16'h0200, 16'h0, 16'h7777, 0, 0);
`ifdef ST4_MEM_ALIGN_CHECK_EN
    tick();
    checks++; if (excpt !== 1'b1 || excCause !== 2'b11 || epc !== 16'h0060) begin
      failures++; $display("FAIL range_capture got=%b/%b/%h exp=1/11/0060", excpt, excCause, epc);
    end
    drive(1, 16'h0062, 0, 0, 1, 0, 4'd4, 16'h1111, 16'h0, 16'h0, 0, 1);
    tick();
    checks++; if (wbValid !== 1'b0) begin
      failures++; $display("FAIL range_clear_drop got=%b exp=0", wbValid);
    end
    drive(1, 16'h0064, 1, 0, 1, 0, 4'd1, 16'h0000, 16'h0, 16'h0, 0, 0);
    tick();
    checks++; if (wbValid !== 1'b1 || wbData !== 16'h0A0A) begin
      failures++; $display("FAIL range_mem got=%b/%h exp=1/0a0a", wbValid, wbData);
    end
`else
    tick();
    checks++; if (wbValid !== 1'b1 || excpt !== 1'b0) begin
      failures++; $display("FAIL range_wrap_store got=%b/%b exp=1/0", wbValid, excpt);
    end
    // excClear while running must not disturb anything.
    drive(1, 16'h0064, 1, 0, 1, 0, 4'd1, 16'h0000, 16'h0, 16'h0, 0, 1);
    #1;
    checks++; if (flush !== 1'b0) begin
      failures++; $display("FAIL run_clear_flush got=%b exp=0", flush);
    end
    tick();
    checks++; if (wbValid !== 1'b1 || wbData !== 16'h7777) begin
      failures++; $display("FAIL range_wrap_load got=%b/%h exp=1/7777", wbValid, wbData);
    end
`endif
  endtask

  task automatic test_priority();
    // Overflow beats both address faults.
    drive(1, 16'h0070, 0, 1, 0, 0, 4'd0, 16'h0201, 16'h0, 16'h9999, 1, 0);
    tick();
    checks++; if (excpt !== 1'b1 || excCause !== 2'b01 || epc !== 16'h0070) begin
      failures++; $display("FAIL prio_ovf got=%b/%b/%h exp=1/01/0070", excpt, excCause, epc);
    end
    drive(0, 16'h0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 1);
    tick();
`ifdef ST4_MEM_ALIGN_CHECK_EN
    // Misaligned beats out of range.
    drive(1, 16'h0072, 1, 0, 1, 0, 4'd0, 16'h0201, 16'h0, 16'h0, 0, 0);
    tick();
    checks++; if (excpt !== 1'b1 || excCause !== 2'b10 || epc !== 16'h0072) begin
      failures++; $display("FAIL prio_align got=%b/%b/%h exp=1/10/0072", excpt, excCause, epc);
    end
    drive(0, 16'h0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 1);
    tick();
`endif
  endtask

  task automatic test_back_to_back();
    drive(1, 16'h0100, 0, 1, 0, 0, 4'd0, 16'h0020, 16'h0, 16'hAAAA, 0, 0);
    tick();
    drive(1, 16'h0102, 1, 0, 1, 0, 4'd6, 16'h0020, 16'h0, 16'h0, 0, 0);
    tick();
    checks++; if (wbData !== 16'hAAAA || wbValid !== 1'b1) begin
      failures++; $display("FAIL b2b_load1 got=%b/%h exp=1/aaaa", wbValid, wbData);
    end
    drive(1, 16'h0104, 0, 0, 1, 0, 4'd6, 16'h1357, 16'h2468, 16'h0, 0, 0);
    tick();
    checks++; if (wbData !== 16'h1357 || wbData2 !== 16'h2468) begin
      failures++; $display("FAIL b2b_alu got=%h/%h exp=1357/2468", wbData, wbData2);
    end
    drive(1, 16'h0106, 0, 1, 0, 0, 4'd0, 16'h0020, 16'h0, 16'h5A5A, 0, 0);
    tick();
    drive(1, 16'h0108, 1, 0, 1, 0, 4'd8, 16'h0020, 16'h0, 16'h0, 0, 0);
    tick();
    checks++; if (wbData !== 16'h5A5A || wbReg !== 4'd8) begin
      failures++; $display("FAIL b2b_load2 got=%h/%0d exp=5a5a/8", wbData, wbReg);
    end
  endtask

  task automatic test_reset_in_halt();
    drive(1, 16'h0080, 0, 0, 1, 0, 4'd2, 16'h0001, 16'h0, 16'h0, 1, 0);
    tick();
    checks++; if (excpt !== 1'b1 || epc !== 16'h0080) begin
      failures++; $display("FAIL rh_enter got=%b/%h exp=1/0080", excpt, epc);
    end
    drive(0, 16'h0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 0);
    rst = 1'b1;
    tick();
    checks++; if ({wbValid, wbRegWrite, wbR15Write, excpt, flush} !== 5'b0) begin
      failures++; $display("FAIL rh_ctrl got=%b exp=00000", {wbValid, wbRegWrite, wbR15Write, excpt, flush});
    end
    checks++; if ({wbReg, excCause, wbData, wbData2, epc} !== 54'h0) begin
      failures++; $display("FAIL rh_data got=%h exp=0", {wbReg, excCause, wbData, wbData2, epc});
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1, 16'h0082, 0, 0, 1, 0, 4'd9, 16'h0042, 16'h0, 16'h0, 0, 0);
    tick();
    checks++; if (wbValid !== 1'b1 || wbData !== 16'h0042 || wbReg !== 4'd9) begin
      failures++; $display("FAIL rh_run got=%b/%h/%0d exp=1/0042/9", wbValid, wbData, wbReg);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_passthru();
    test_bubble();
    test_overflow();
    test_misaligned();
    test_range();
    test_priority();
    test_back_to_back();
    test_reset_in_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
